scc_config_mem_shadowed: RTL and testbench

- Clocked, parametrised successor to the per-tile frame-latch configuration memory.
- Frames are written into a shadow array using the existing FrameData/FrameStrobe protocol.
- A Commit pulse copies the whole shadow array into the active ConfigBits in one cycle, so a tile is never partially reconfigured.
- Adds per-frame write tracking, strobe-error detection and a registered frame readback port for configuration verification.

---
 rtl/scc_config_mem_shadowed_if.sv | 35 +++
 rtl/scc_config_mem_shadowed.sv | 111 +++++++++++
 tb/tb_scc_config_mem_shadowed.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/scc_config_mem_shadowed_if.sv
// Configuration-memory bus: frame write, commit, readback and status.
// The master drives frames and read requests. The slave returns readback data and configuration.
interface scc_config_mem_shadowed_if #(
  parameter int MAX_FRAMES_PER_COL = 20,
  parameter int FRAME_BITS_PER_ROW = 32,
  parameter int NO_CONFIG_BITS     = 640,
  parameter int SEL_W              = $clog2(MAX_FRAMES_PER_COL)
);
  logic [FRAME_BITS_PER_ROW-1:0] frame_data;
  logic [MAX_FRAMES_PER_COL-1:0] frame_strobe;
  logic                          commit;
  logic                          read_en;
  logic [SEL_W-1:0]              read_sel;
  logic                          read_shadow;
  logic [FRAME_BITS_PER_ROW-1:0] read_data;
  logic                          read_valid;
  logic [MAX_FRAMES_PER_COL-1:0] frames_written;
  logic                          all_written;
  logic                          pending;
  logic                          strobe_error;
  logic [NO_CONFIG_BITS-1:0]     config_bits;
  logic [NO_CONFIG_BITS-1:0]     config_bits_n;

  modport master (
    output frame_data, frame_strobe, commit, read_en, read_sel, read_shadow,
    input  read_data, read_valid, frames_written, all_written, pending,
           strobe_error, config_bits, config_bits_n
  );

  modport slave (
    input  frame_data, frame_strobe, commit, read_en, read_sel, read_shadow,
    output read_data, read_valid, frames_written, all_written, pending,
           strobe_error, config_bits, config_bits_n
  );
endinterface

// File: rtl/scc_config_mem_shadowed.sv
// Shadowed tile configuration memory. Frames are written into a shadow array.
// A commit copies the shadow array into the active array atomically. A registered readback port is provided for verification.
module scc_config_mem_shadowed #(
  parameter int                        MAX_FRAMES_PER_COL = 20,
  parameter int                        FRAME_BITS_PER_ROW = 32,
  parameter int                        NO_CONFIG_BITS     = 640,
  parameter logic [NO_CONFIG_BITS-1:0] RESET_BITSTREAM    = '0,
  parameter int                        SEL_W              = $clog2(MAX_FRAMES_PER_COL)
) (
  input logic                        i_clk,
  input logic                        i_rst,
  scc_config_mem_shadowed_if.slave   io_cfg
);
  localparam int FULL_W = MAX_FRAMES_PER_COL * FRAME_BITS_PER_ROW;
  localparam logic [MAX_FRAMES_PER_COL-1:0] STROBE_ONE = {{(MAX_FRAMES_PER_COL-1){1'b0}}, 1'b1};
  localparam logic [SEL_W:0] SEL_LIMIT = (SEL_W+1)'(MAX_FRAMES_PER_COL);

  logic [NO_CONFIG_BITS-1:0]     r_shadow;
  logic [NO_CONFIG_BITS-1:0]     r_active;
  logic [MAX_FRAMES_PER_COL-1:0] r_frames_written;
  logic                          r_strobe_error;
  logic                          r_read_valid;
  logic [FRAME_BITS_PER_ROW-1:0] r_read_data;

  logic [FULL_W-1:0]             w_shadow_full;
  logic [FULL_W-1:0]             w_active_full;
  logic [FULL_W-1:0]             w_shadow_next;
  logic [FRAME_BITS_PER_ROW-1:0] w_shadow_frm [MAX_FRAMES_PER_COL];
  logic [FRAME_BITS_PER_ROW-1:0] w_active_frm [MAX_FRAMES_PER_COL];
  logic                          w_strobe_any;
  logic                          w_write_ok;
  logic                          w_strobe_multi;
  logic [MAX_FRAMES_PER_COL-1:0] w_frames_written_next;
  logic [FRAME_BITS_PER_ROW-1:0] w_read_frame;

  // One-hot strobe writes a frame. A multi-hot strobe is rejected and flagged.
  assign w_strobe_any   = |io_cfg.frame_strobe;
  assign w_write_ok     = w_strobe_any &&
                          ((io_cfg.frame_strobe & (io_cfg.frame_strobe - STROBE_ONE)) == '0);
  assign w_strobe_multi = w_strobe_any && !w_write_ok;

  // Zero-pad stored bits to whole frames; bits beyond NO_CONFIG_BITS read as 0
  always_comb begin
    w_shadow_full = '0;
    w_active_full = '0;
    w_shadow_full[NO_CONFIG_BITS-1:0] = r_shadow;
    w_active_full[NO_CONFIG_BITS-1:0] = r_active;
  end

  for (genvar g = 0; g < MAX_FRAMES_PER_COL; g++) begin : g_frame
    assign w_shadow_frm[g] = w_shadow_full[g*FRAME_BITS_PER_ROW +: FRAME_BITS_PER_ROW];
    assign w_active_frm[g] = w_active_full[g*FRAME_BITS_PER_ROW +: FRAME_BITS_PER_ROW];
    assign w_shadow_next[g*FRAME_BITS_PER_ROW +: FRAME_BITS_PER_ROW] =
      (w_write_ok && io_cfg.frame_strobe[g]) ? io_cfg.frame_data : w_shadow_frm[g];
  end

  // Write-tracking next state; commit wins so a same-cycle write leaves it at zero
  always_comb begin
    w_frames_written_next = r_frames_written;
    if (io_cfg.commit) begin
      w_frames_written_next = '0;
    end else if (w_write_ok) begin
      w_frames_written_next = r_frames_written | io_cfg.frame_strobe;
    end else begin
      w_frames_written_next = r_frames_written;
    end
  end

  // Readback selects from pre-edge state, giving read-before-write behaviour
  always_comb begin
    w_read_frame = '0;
    if ({1'b0, io_cfg.read_sel} < SEL_LIMIT) begin
      w_read_frame = io_cfg.read_shadow ? w_shadow_frm[io_cfg.read_sel]
                                        : w_active_frm[io_cfg.read_sel];
    end else begin
      w_read_frame = '0;
    end
  end

  // State registers; reset overrides any concurrent write, commit or read
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow         <= RESET_BITSTREAM;
      r_active         <= RESET_BITSTREAM;
      r_frames_written <= '0;
      r_strobe_error   <= 1'b0;
      r_read_valid     <= 1'b0;
      r_read_data      <= '0;
    end else begin
      r_shadow         <= w_shadow_next[NO_CONFIG_BITS-1:0];
      r_frames_written <= w_frames_written_next;
      r_strobe_error   <= r_strobe_error | w_strobe_multi;
      r_read_valid     <= io_cfg.read_en;
      if (io_cfg.commit) begin
        r_active <= w_shadow_next[NO_CONFIG_BITS-1:0];
      end
      if (io_cfg.read_en) begin
        r_read_data <= w_read_frame;
      end
    end
  end

  assign io_cfg.config_bits    = r_active;
  assign io_cfg.config_bits_n  = ~r_active;
  assign io_cfg.frames_written = r_frames_written;
  assign io_cfg.all_written    = &r_frames_written;
  assign io_cfg.pending        = |r_frames_written;
  assign io_cfg.strobe_error   = r_strobe_error;
  assign io_cfg.read_valid     = r_read_valid;
  assign io_cfg.read_data      = r_read_data;
endmodule

// File: tb/tb_scc_config_mem_shadowed.sv
// Directed bench for scc_config_mem_shadowed with hand-computed expectations.
// Inputs change and outputs are sampled on the falling edge.
module tb_scc_config_mem_shadowed;
  localparam int MF  = 20;
  localparam int FB  = 32;
  localparam int NCB = 640;
  localparam logic [NCB-1:0] RB = {{(NCB-8){1'b0}}, 8'hA5};

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  scc_config_mem_shadowed_if #(.MAX_FRAMES_PER_COL(MF), .FRAME_BITS_PER_ROW(FB),
                               .NO_CONFIG_BITS(NCB)) cfg_if ();

  scc_config_mem_shadowed #(.MAX_FRAMES_PER_COL(MF), .FRAME_BITS_PER_ROW(FB),
                            .NO_CONFIG_BITS(NCB), .RESET_BITSTREAM(RB)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_cfg (cfg_if)
  );

  task automatic idle();
    cfg_if.frame_data   = 32'h0;
    cfg_if.frame_strobe = 20'h0;
    cfg_if.commit       = 1'b0;
    cfg_if.read_en      = 1'b0;
    cfg_if.read_sel     = 5'd0;
    cfg_if.read_shadow  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_vec++; if (cfg_if.config_bits[7:0] !== 8'hA5) begin n_err++;
      $display("FAIL reset_cfg_lo: got %h expected a5", cfg_if.config_bits[7:0]); end
    n_vec++; if (cfg_if.config_bits_n[7:0] !== 8'h5A) begin n_err++;
      $display("FAIL reset_cfgn_lo: got %h expected 5a", cfg_if.config_bits_n[7:0]); end
    n_vec++; if (cfg_if.config_bits !== RB) begin n_err++;
      $display("FAIL reset_cfg_full: upper bits not zero"); end
    n_vec++; if ({cfg_if.frames_written, cfg_if.all_written, cfg_if.pending,
                  cfg_if.strobe_error, cfg_if.read_valid} !== 24'h0) begin n_err++;
      $display("FAIL reset_flags: got fw=%h aw=%b p=%b se=%b rv=%b expected all 0",
               cfg_if.frames_written, cfg_if.all_written, cfg_if.pending,
               cfg_if.strobe_error, cfg_if.read_valid); end
    n_vec++; if (cfg_if.read_data !== 32'h0) begin n_err++;
      $display("FAIL reset_rdata: got %h expected 0", cfg_if.read_data); end
  endtask

  task automatic test_single_commit();
    cfg_if.frame_strobe = 20'h00001;
    cfg_if.frame_data   = 32'hDEADBEEF;
    tick();
    idle();
    n_vec++; if (cfg_if.config_bits[31:0] !== 32'h000000A5) begin n_err++;
      $display("FAIL pre_commit_cfg: got %h expected 000000a5", cfg_if.config_bits[31:0]); end
    n_vec++; if (cfg_if.frames_written !== 20'h00001 || cfg_if.pending !== 1'b1) begin n_err++;
      $display("FAIL write_track: got fw=%h p=%b expected 00001 1",
               cfg_if.frames_written, cfg_if.pending); end
    cfg_if.commit = 1'b1;
    tick();
    idle();
    n_vec++; if (cfg_if.config_bits[31:0] !== 32'hDEADBEEF) begin n_err++;
      $display("FAIL commit_cfg: got %h expected deadbeef", cfg_if.config_bits[31:0]); end
    n_vec++; if (cfg_if.config_bits_n[31:0] !== 32'h21524110) begin n_err++;
      $display("FAIL commit_cfgn: got %h expected 21524110", cfg_if.config_bits_n[31:0]); end
    n_vec++; if (cfg_if.frames_written !== 20'h0 || cfg_if.pending !== 1'b0) begin n_err++;
      $display("FAIL commit_clear: got fw=%h p=%b expected 0 0",
               cfg_if.frames_written, cfg_if.pending); end
  endtask

  task automatic test_all_frames();
    for (int f = 0; f < MF; f++) begin
      cfg_if.frame_strobe    = 20'h0;
      cfg_if.frame_strobe[f] = 1'b1;
      cfg_if.frame_data      = 32'(f + 1);
      tick();
      if (f == MF - 2) begin
        n_vec++; if (cfg_if.all_written !== 1'b0) begin n_err++;
          $display("FAIL all_written_early: got %b expected 0", cfg_if.all_written); end
      end
    end
    idle();
    n_vec++; if (cfg_if.all_written !== 1'b1 || cfg_if.pending !== 1'b1 ||
                 cfg_if.frames_written !== 20'hFFFFF) begin n_err++;
      $display("FAIL all_written: got aw=%b p=%b fw=%h expected 1 1 fffff",
               cfg_if.all_written, cfg_if.pending, cfg_if.frames_written); end
    cfg_if.commit = 1'b1;
    tick();
    idle();
    n_vec++; if (cfg_if.config_bits[639:608] !== 32'h00000014) begin n_err++;
      $display("FAIL all_commit_top: got %h expected 00000014", cfg_if.config_bits[639:608]); end
    n_vec++; if (cfg_if.config_bits[31:0] !== 32'h00000001) begin n_err++;
      $display("FAIL all_commit_f0: got %h expected 00000001", cfg_if.config_bits[31:0]); end
    n_vec++; if (cfg_if.all_written !== 1'b0) begin n_err++;
      $display("FAIL all_commit_aw: got %b expected 0", cfg_if.all_written); end
  endtask

  task automatic test_strobe_error();
    cfg_if.frame_strobe = 20'h00003;
    cfg_if.frame_data   = 32'hFFFFFFFF;
    tick();
    idle();
    n_vec++; if (cfg_if.strobe_error !== 1'b1 || cfg_if.frames_written !== 20'h0) begin n_err++;
      $display("FAIL strobe_err: got se=%b fw=%h expected 1 00000",
               cfg_if.strobe_error, cfg_if.frames_written); end
    cfg_if.read_en = 1'b1; cfg_if.read_shadow = 1'b1; cfg_if.read_sel = 5'd0;
    tick();
    n_vec++; if (cfg_if.read_data !== 32'h00000001 || cfg_if.read_valid !== 1'b1) begin n_err++;
      $display("FAIL strobe_sh_f0: got %h v=%b expected 00000001 1",
               cfg_if.read_data, cfg_if.read_valid); end
    cfg_if.read_sel = 5'd1;
    tick();
    idle();
    n_vec++; if (cfg_if.read_data !== 32'h00000002) begin n_err++;
      $display("FAIL strobe_sh_f1: got %h expected 00000002", cfg_if.read_data); end
    cfg_if.commit = 1'b1;
    tick();
    idle();
    n_vec++; if (cfg_if.strobe_error !== 1'b1) begin n_err++;
      $display("FAIL strobe_sticky: got %b expected 1", cfg_if.strobe_error); end
    n_vec++; if (cfg_if.config_bits[63:32] !== 32'h00000002) begin n_err++;
      $display("FAIL strobe_cfg_f1: got %h expected 00000002", cfg_if.config_bits[63:32]); end
  endtask

  task automatic test_write_commit();
    cfg_if.frame_strobe = 20'h00020;
    cfg_if.frame_data   = 32'h12345678;
    cfg_if.commit       = 1'b1;
    tick();
    idle();
    n_vec++; if (cfg_if.config_bits[191:160] !== 32'h12345678) begin n_err++;
      $display("FAIL wc_cfg_f5: got %h expected 12345678", cfg_if.config_bits[191:160]); end
    n_vec++; if (cfg_if.frames_written !== 20'h0) begin n_err++;
      $display("FAIL wc_fw: got %h expected 00000", cfg_if.frames_written); end
  endtask

  task automatic test_readback();
    cfg_if.frame_strobe = 20'h00020; cfg_if.frame_data = 32'hCAFEF00D;
    cfg_if.read_en = 1'b1; cfg_if.read_sel = 5'd5; cfg_if.read_shadow = 1'b0;
    tick();
    n_vec++; if (cfg_if.read_data !== 32'h12345678 || cfg_if.read_valid !== 1'b1) begin n_err++;
      $display("FAIL rbw_active: got %h v=%b expected 12345678 1",
               cfg_if.read_data, cfg_if.read_valid); end
    cfg_if.frame_data = 32'h0BADBEEF; cfg_if.read_shadow = 1'b1;
    tick();
    idle();
    n_vec++; if (cfg_if.read_data !== 32'hCAFEF00D) begin n_err++;
      $display("FAIL rbw_shadow: got %h expected cafef00d", cfg_if.read_data); end
    tick();
    n_vec++; if (cfg_if.read_valid !== 1'b0 || cfg_if.read_data !== 32'hCAFEF00D) begin n_err++;
      $display("FAIL read_hold: got %h v=%b expected cafef00d 0",
               cfg_if.read_data, cfg_if.read_valid); end
    cfg_if.read_en = 1'b1; cfg_if.read_sel = 5'd25;
    tick();
    n_vec++; if (cfg_if.read_data !== 32'h0 || cfg_if.read_valid !== 1'b1) begin n_err++;
      $display("FAIL read_oob: got %h v=%b expected 00000000 1",
               cfg_if.read_data, cfg_if.read_valid); end
    cfg_if.read_sel = 5'd2; cfg_if.read_shadow = 1'b0;
    tick();
    n_vec++; if (cfg_if.read_data !== 32'h00000003) begin n_err++;
      $display("FAIL b2b_first: got %h expected 00000003", cfg_if.read_data); end
    cfg_if.read_sel = 5'd3; cfg_if.read_shadow = 1'b1;
    tick();
    idle();
    n_vec++; if (cfg_if.read_data !== 32'h00000004 || cfg_if.read_valid !== 1'b1) begin n_err++;
      $display("FAIL b2b_second: got %h v=%b expected 00000004 1",
               cfg_if.read_data, cfg_if.read_valid); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    cfg_if.frame_strobe = 20'h00080; cfg_if.frame_data = 32'h55AA55AA;
    cfg_if.commit = 1'b1; cfg_if.read_en = 1'b1; cfg_if.read_sel = 5'd5;
    tick();
    rst = 1'b0;
    idle();
    n_vec++; if (cfg_if.config_bits !== RB || cfg_if.config_bits_n !== ~RB) begin n_err++;
      $display("FAIL rstmid_cfg: got lo=%h expected lo=000000a5 with zero upper bits",
               cfg_if.config_bits[31:0]); end
    n_vec++; if ({cfg_if.frames_written, cfg_if.strobe_error, cfg_if.read_valid} !== 22'h0 ||
                 cfg_if.read_data !== 32'h0) begin n_err++;
      $display("FAIL rstmid_flags: got fw=%h se=%b rv=%b rd=%h expected all 0",
               cfg_if.frames_written, cfg_if.strobe_error, cfg_if.read_valid,
               cfg_if.read_data); end
    cfg_if.read_en = 1'b1; cfg_if.read_sel = 5'd0; cfg_if.read_shadow = 1'b1;
    tick();
    n_vec++; if (cfg_if.read_data !== 32'h000000A5) begin n_err++;
      $display("FAIL rstmid_sh_f0: got %h expected 000000a5", cfg_if.read_data); end
    cfg_if.read_sel = 5'd7;
    tick();
    idle();
    n_vec++; if (cfg_if.read_data !== 32'h0) begin n_err++;
      $display("FAIL rstmid_sh_f7: got %h expected 00000000", cfg_if.read_data); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_single_commit();
    test_all_frames();
    test_strobe_error();
    test_write_commit();
    test_readback();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
